// File: rtl/vector_addsub_folded_pkg.sv
// Shared types and elaboration helpers for the folded vector add/sub block.
// Holds the FSM state encoding and the group-count / counter-width math.
package vecadd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Narrowest group counter allowed, so a single-pass build still has a real register.
    localparam int GRP_W_MIN = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int passes(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    function automatic int grp_width(input int n, input int lanes);
        int w;
        w = clog2(passes(n, lanes));
        return (w < GRP_W_MIN) ? GRP_W_MIN : w;
    endfunction

endpackage

// File: rtl/vector_addsub_folded_lane.sv
// One physical add/sub unit: sign-extends both operands and adds or subtracts.
// With VECADD_SAT_EN defined the result is clamped to the input range and flagged.
module addsub_lane
    import vecadd_pkg::*;
#(
    parameter int IN_WIDTH = 10
) (
    input  logic [IN_WIDTH-1:0] a_i,
    input  logic [IN_WIDTH-1:0] b_i,
    input  logic                sub_i,
    output logic [IN_WIDTH:0]   res_o
`ifdef VECADD_SAT_EN
    ,
    output logic                sat_o
`endif
);

    logic signed [IN_WIDTH:0] a_ext;
    logic signed [IN_WIDTH:0] b_ext;
    logic signed [IN_WIDTH:0] sum;

    assign a_ext = {a_i[IN_WIDTH-1], a_i};
    assign b_ext = {b_i[IN_WIDTH-1], b_i};
    assign sum   = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);

`ifdef VECADD_SAT_EN
    // Top two bits disagree exactly when the value left the IN_WIDTH signed range.
    function automatic logic [IN_WIDTH:0] clamp(input logic [IN_WIDTH:0] v);
        if (v[IN_WIDTH] != v[IN_WIDTH-1])
            return {v[IN_WIDTH], v[IN_WIDTH], {(IN_WIDTH-1){~v[IN_WIDTH]}}};
        return v;
    endfunction

    assign sat_o = sum[IN_WIDTH] ^ sum[IN_WIDTH-1];
    assign res_o = clamp(sum);
`else
    assign res_o = sum;
`endif

endmodule

// File: rtl/vector_addsub_folded.sv
// Time-multiplexed N-element vector add/sub using LANES units over ceil(N/LANES) cycles.
// Optional build macro: VECADD_SAT_EN (clamped results plus a sat pulse output).
module vector_addsub_folded
    import vecadd_pkg::*;
#(
    parameter int IN_WIDTH = 10,
    parameter int N        = 11,
    parameter int LANES    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         inReady,
    input  logic                         sub,
    input  logic [N*IN_WIDTH-1:0]        A,
    input  logic [N*IN_WIDTH-1:0]        B,
    output logic [N*(IN_WIDTH+1)-1:0]    S,
    output logic                         outReady,
    output logic                         earlyOutReady,
    output logic                         busy,
    output logic                         overrun
`ifdef VECADD_SAT_EN
    ,
    output logic                         sat
`endif
);

    localparam int OUT_W  = IN_WIDTH + 1;
    localparam int PASSES = passes(N, LANES);
    localparam int GRP_W  = grp_width(N, LANES);
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(PASSES - 1);

    state_e             state_q, state_d;
    logic [GRP_W-1:0]   grp_q, grp_d;
    logic               accept;
    logic               last_grp;

    logic [N*IN_WIDTH-1:0] a_q, b_q;
    logic                  sub_q;

    logic [IN_WIDTH-1:0] a_grp [PASSES][LANES];
    logic [IN_WIDTH-1:0] b_grp [PASSES][LANES];
    logic [IN_WIDTH-1:0] lane_a [LANES];
    logic [IN_WIDTH-1:0] lane_b [LANES];
    logic [OUT_W-1:0]    lane_res [LANES];
    logic [LANES-1:0]    lane_vld;

    logic [OUT_W-1:0]    work_q [PASSES][LANES];
    logic [OUT_W-1:0]    work_m [PASSES][LANES];
    logic [N*OUT_W-1:0]  s_flat;

    logic [N*OUT_W-1:0]  s_q, s_d;
    logic                out_q, out_d;
    logic                early_q, early_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;

`ifdef VECADD_SAT_EN
    logic [LANES-1:0]    lane_sat;
    logic                sat_any;
    logic                sat_acc_q;
    logic                sat_q, sat_d;
`endif

    assign last_grp = (state_q == RUN) && (grp_q == LAST_GRP);
    assign accept   = enable && inReady && ((state_q == IDLE) || last_grp);

    // Operand slots arranged by group; slots past N read as zero so spare lanes idle.
    for (genvar g = 0; g < PASSES; g++) begin : g_grp
        for (genvar l = 0; l < LANES; l++) begin : g_slot
            if (g * LANES + l < N) begin : g_used
                assign a_grp[g][l] = a_q[(g*LANES+l)*IN_WIDTH +: IN_WIDTH];
                assign b_grp[g][l] = b_q[(g*LANES+l)*IN_WIDTH +: IN_WIDTH];
            end else begin : g_pad
                assign a_grp[g][l] = '0;
                assign b_grp[g][l] = '0;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_a[l]   = a_grp[grp_q][l];
        assign lane_b[l]   = b_grp[grp_q][l];
        assign lane_vld[l] = (int'(grp_q) * LANES + l) < N;

        addsub_lane #(
            .IN_WIDTH (IN_WIDTH)
        ) u_lane (
            .a_i   (lane_a[l]),
            .b_i   (lane_b[l]),
            .sub_i (sub_q),
            .res_o (lane_res[l])
`ifdef VECADD_SAT_EN
            ,
            .sat_o (lane_sat[l])
`endif
        );
    end

    // Working register with the current group's lanes merged in; also feeds S on the last group.
    always_comb begin
        work_m = work_q;
        for (int l = 0; l < LANES; l++) begin
            if (lane_vld[l]) work_m[grp_q][l] = lane_res[l];
        end
    end

    for (genvar e = 0; e < N; e++) begin : g_out
        assign s_flat[e*OUT_W +: OUT_W] = work_m[e / LANES][e % LANES];
    end

`ifdef VECADD_SAT_EN
    assign sat_any = |(lane_sat & lane_vld);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grp_q   <= '0;
        end else if (enable) begin
            state_q <= state_d;
            grp_q   <= grp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        if (accept) begin
            state_d = RUN;
            grp_d   = '0;
        end else if (last_grp) begin
            state_d = IDLE;
            grp_d   = '0;
        end else if (state_q == RUN) begin
            grp_d   = grp_q + GRP_W'(1);
        end
    end

    always_comb begin
        early_d   = (state_d == RUN) && (grp_d == LAST_GRP);
        out_d     = last_grp;
        busy_d    = (state_d == RUN);
        overrun_d = inReady && !accept;
        s_d       = last_grp ? s_flat : s_q;
`ifdef VECADD_SAT_EN
        sat_d     = last_grp && (sat_acc_q || sat_any);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q       <= '0;
            out_q     <= 1'b0;
            early_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef VECADD_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else if (enable) begin
            s_q       <= s_d;
            out_q     <= out_d;
            early_q   <= early_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef VECADD_SAT_EN
            sat_q     <= sat_d;
`endif
        end
    end

    // Datapath registers carry no reset; a new vector overwrites every live slot before use.
    always_ff @(posedge clk) begin
        if (enable) begin
            if (accept) begin
                a_q   <= A;
                b_q   <= B;
                sub_q <= sub;
            end
            if (state_q == RUN) work_q <= work_m;
`ifdef VECADD_SAT_EN
            if (accept)               sat_acc_q <= 1'b0;
            else if (state_q == RUN)  sat_acc_q <= sat_acc_q | sat_any;
`endif
        end
    end

    assign S             = s_q;
    assign outReady      = out_q;
    assign earlyOutReady = early_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
`ifdef VECADD_SAT_EN
    assign sat           = sat_q;
`endif

endmodule

// File: tb/tb_vector_addsub_folded.sv
// Bench for vector_addsub_folded: default N=11/LANES=4 plus LANES=11 and LANES=1 builds.
module tb_vector_addsub_folded;

    localparam int W  = 10;
    localparam int NN = 11;
    localparam int OW = W + 1;
    localparam int AW = NN * W;
    localparam int SW = NN * OW;

    typedef struct {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic          sub;
        logic [SW-1:0] s;
        logic          sat;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset, enable, inReady, sub;
    logic [AW-1:0] A, B;
    logic [SW-1:0] S;
    logic          outReady, earlyOutReady, busy, overrun;

    logic          e_inReady, e_sub;
    logic [AW-1:0] e_A, e_B;
    logic [SW-1:0] S11, S1;
    logic          out11, early11, busy11, ovr11;
    logic          out1, early1, busy1, ovr1;
`ifdef VECADD_SAT_EN
    logic          sat, sat11, sat1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl [8];

    always #5 clk = ~clk;

    vector_addsub_folded #(.IN_WIDTH(W), .N(NN), .LANES(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .inReady(inReady), .sub(sub),
        .A(A), .B(B), .S(S), .outReady(outReady), .earlyOutReady(earlyOutReady),
        .busy(busy), .overrun(overrun)
`ifdef VECADD_SAT_EN
        , .sat(sat)
`endif
    );

    vector_addsub_folded #(.IN_WIDTH(W), .N(NN), .LANES(11)) dut_l11 (
        .clk(clk), .reset(reset), .enable(enable), .inReady(e_inReady), .sub(e_sub),
        .A(e_A), .B(e_B), .S(S11), .outReady(out11), .earlyOutReady(early11),
        .busy(busy11), .overrun(ovr11)
`ifdef VECADD_SAT_EN
        , .sat(sat11)
`endif
    );

    vector_addsub_folded #(.IN_WIDTH(W), .N(NN), .LANES(1)) dut_l1 (
        .clk(clk), .reset(reset), .enable(enable), .inReady(e_inReady), .sub(e_sub),
        .A(e_A), .B(e_B), .S(S1), .outReady(out1), .earlyOutReady(early1),
        .busy(busy1), .overrun(ovr1)
`ifdef VECADD_SAT_EN
        , .sat(sat1)
`endif
    );

    // Reference: per-element integer arithmetic, optionally clamped to the input range.
    function automatic logic [SW-1:0] model(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic s, output logic any_sat);
        logic [SW-1:0] r;
        logic [31:0]   zb;
        int x, y, z;
        r = '0;
        any_sat = 1'b0;
        for (int i = 0; i < NN; i++) begin
            x = int'($signed(a[i*W +: W]));
            y = int'($signed(b[i*W +: W]));
            z = s ? (x - y) : (x + y);
`ifdef VECADD_SAT_EN
            if (z > 2**(W-1) - 1) begin z = 2**(W-1) - 1; any_sat = 1'b1; end
            else if (z < -(2**(W-1))) begin z = -(2**(W-1)); any_sat = 1'b1; end
`endif
            zb = z;
            r[i*OW +: OW] = zb[OW-1:0];
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] rnd_vec();
        logic [AW-1:0] v;
        for (int i = 0; i < NN; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i*W +: W] = 10'h200;
                1:       v[i*W +: W] = 10'h1FF;
                default: v[i*W +: W] = W'($urandom_range(0, 2**W - 1));
            endcase
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int            early_c, out_c;
        logic [SW-1:0] s_cap;
        logic          busy4, sat_cap;
        A = v.a; B = v.b; sub = v.sub; inReady = 1'b1;
        tick();
        inReady = 1'b0;
        check({tag, "_busy_c0"}, 128'(busy), 128'(1));
        early_c = -1; out_c = -1; s_cap = '0; busy4 = 1'b1; sat_cap = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (earlyOutReady && early_c < 0) early_c = c;
            if (outReady && out_c < 0) begin
                out_c = c;
                s_cap = S;
`ifdef VECADD_SAT_EN
                sat_cap = sat;
`endif
            end
            if (c == 4) busy4 = busy;
            tick();
        end
        check({tag, "_early_cycle"}, 128'(early_c), 128'(2));
        check({tag, "_out_cycle"}, 128'(out_c), 128'(3));
        check({tag, "_S"}, 128'(s_cap), 128'(v.s));
        check({tag, "_busy_c4"}, 128'(busy4), 128'(0));
`ifdef VECADD_SAT_EN
        check({tag, "_sat"}, 128'(sat_cap), 128'(v.sat));
`else
        check({tag, "_nosat"}, 128'(sat_cap), 128'(v.sat & 1'b0));
`endif
    endtask

    initial begin
        logic          dummy;
        logic [SW-1:0] s11c, s1c;
        int            o11, o1, e11, e1, out_c;
        logic          seen;
        vec_t          v;

        // Directed rows with hand-derived results, then random rows scored by the model.
        for (int k = 0; k < 8; k++) begin
            tbl[k].a = '0; tbl[k].b = '0; tbl[k].sub = 1'b0; tbl[k].s = '0; tbl[k].sat = 1'b0;
        end
        for (int i = 0; i < NN; i++) begin
            tbl[0].a[i*W +: W]  = W'(i);
            tbl[0].b[i*W +: W]  = W'(10 * i);
            tbl[0].s[i*OW +: OW] = OW'(11 * i);
        end
        tbl[1].a[0 +: W] = 10'h200;
        tbl[1].b[0 +: W] = 10'h1FF;
        tbl[1].sub       = 1'b1;
`ifdef VECADD_SAT_EN
        tbl[1].s[0 +: OW] = 11'h600;
        tbl[1].sat        = 1'b1;
`else
        tbl[1].s[0 +: OW] = 11'h401;
`endif
        for (int i = 0; i < NN; i++) begin
            tbl[2].a[i*W +: W] = 10'h1FF;
            tbl[2].b[i*W +: W] = 10'h1FF;
`ifdef VECADD_SAT_EN
            tbl[2].s[i*OW +: OW] = 11'h1FF;
            tbl[2].sat = 1'b1;
`else
            tbl[2].s[i*OW +: OW] = 11'h3FE;
`endif
        end
        for (int k = 3; k < 8; k++) begin
            tbl[k].a   = rnd_vec();
            tbl[k].b   = rnd_vec();
            tbl[k].sub = 1'($urandom_range(0, 1));
            tbl[k].s   = model(tbl[k].a, tbl[k].b, tbl[k].sub, tbl[k].sat);
        end

        reset = 1'b1; enable = 1'b1; inReady = 1'b0; sub = 1'b0; A = '0; B = '0;
        e_inReady = 1'b0; e_sub = 1'b0; e_A = '0; e_B = '0;
        tick(); tick();
        reset = 1'b0;
        check("reset_S", 128'(S), 128'(0));
        check("reset_flags", 128'({outReady, earlyOutReady, busy, overrun}), 128'(0));
        check("reset_edge_flags", 128'({out11, early11, busy11, ovr11, out1, early1, busy1, ovr1}), 128'(0));
        check("reset_edge_S", 128'(S11 | S1), 128'(0));

        for (int k = 0; k < 8; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

        // Back-to-back: second vector presented in the first one's last-group cycle.
        A = tbl[3].a; B = tbl[3].b; sub = tbl[3].sub; inReady = 1'b1;
        tick(); inReady = 1'b0;
        tick(); tick();
        A = tbl[4].a; B = tbl[4].b; sub = tbl[4].sub; inReady = 1'b1;
        tick(); inReady = 1'b0;
        check("b2b_out1", 128'(outReady), 128'(1));
        check("b2b_S1", 128'(S), 128'(tbl[3].s));
        check("b2b_busy", 128'(busy), 128'(1));
        check("b2b_no_overrun", 128'(overrun), 128'(0));
        tick();
        check("b2b_gap_c4", 128'(outReady), 128'(0));
        tick();
        check("b2b_gap_c5", 128'(outReady), 128'(0));
        check("b2b_S_hold", 128'(S), 128'(tbl[3].s));
        tick();
        check("b2b_out2", 128'(outReady), 128'(1));
        check("b2b_S2", 128'(S), 128'(tbl[4].s));
        tick(); tick(); tick();

        // Input offered during group 1 is dropped with an overrun pulse.
        A = tbl[5].a; B = tbl[5].b; sub = tbl[5].sub; inReady = 1'b1;
        tick(); inReady = 1'b0;
        tick();
        A = tbl[6].a; B = tbl[6].b; sub = tbl[6].sub; inReady = 1'b1;
        tick(); inReady = 1'b0;
        check("ovr_pulse", 128'(overrun), 128'(1));
        tick();
        check("ovr_clear", 128'(overrun), 128'(0));
        check("ovr_out", 128'(outReady), 128'(1));
        check("ovr_S", 128'(S), 128'(tbl[5].s));
        tick(); tick();

        // Two stalled cycles mid-run, with inReady offered while stalled.
        A = tbl[7].a; B = tbl[7].b; sub = tbl[7].sub; inReady = 1'b1;
        tick(); inReady = 1'b0;
        tick();
        enable = 1'b0; A = tbl[0].a; B = tbl[0].b; inReady = 1'b1;
        tick(); tick();
        enable = 1'b1; inReady = 1'b0;
        out_c = -1; seen = 1'b0; s11c = '0;
        for (int c = 3; c < 10; c++) begin
            if (outReady && out_c < 0) begin out_c = c; s11c = S; end
            if (overrun) seen = 1'b1;
            tick();
        end
        check("stall_out_cycle", 128'(out_c), 128'(5));
        check("stall_S", 128'(s11c), 128'(tbl[7].s));
        check("stall_no_overrun", 128'(seen), 128'(0));

        // Reset at group 1 abandons the vector.
        A = tbl[2].a; B = tbl[2].b; sub = tbl[2].sub; inReady = 1'b1;
        tick(); inReady = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_S", 128'(S), 128'(0));
        check("midreset_flags", 128'({outReady, earlyOutReady, busy, overrun}), 128'(0));
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (outReady) seen = 1'b1;
            tick();
        end
        check("midreset_no_out", 128'(seen), 128'(0));

        // Single-pass and single-lane builds must give the same results.
        for (int k = 0; k < 4; k++) begin
            if (k < 3) v = tbl[k];
            else begin
                v.a = rnd_vec(); v.b = rnd_vec(); v.sub = 1'($urandom_range(0, 1));
                v.s = model(v.a, v.b, v.sub, dummy);
            end
            e_A = v.a; e_B = v.b; e_sub = v.sub; e_inReady = 1'b1;
            tick(); e_inReady = 1'b0;
            o11 = -1; o1 = -1; e11 = -1; e1 = -1; s11c = '0; s1c = '0;
            for (int c = 0; c < 15; c++) begin
                if (early11 && e11 < 0) e11 = c;
                if (early1 && e1 < 0) e1 = c;
                if (out11 && o11 < 0) begin o11 = c; s11c = S11; end
                if (out1 && o1 < 0) begin o1 = c; s1c = S1; end
                tick();
            end
            check($sformatf("l11_early_%0d", k), 128'(e11), 128'(0));
            check($sformatf("l11_out_%0d", k), 128'(o11), 128'(1));
            check($sformatf("l11_S_%0d", k), 128'(s11c), 128'(v.s));
            check($sformatf("l1_early_%0d", k), 128'(e1), 128'(10));
            check($sformatf("l1_out_%0d", k), 128'(o1), 128'(11));
            check($sformatf("l1_S_%0d", k), 128'(s1c), 128'(v.s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_addsub_folded.md
# vector_addsub_folded

Parametrised, time-multiplexed successor to the fixed 11-element registered vector adder. It adds or subtracts two signed vectors of `N` elements using only `LANES` physical add/sub units, folding the vector over `PASSES = ceil(N/LANES)` cycles. It keeps the `inReady`/`outReady`/`earlyOutReady` pulse handshake used by the rest of the linear-algebra layer-0 blocks. It sits between vector sources such as matrix-row fetchers and downstream accumulators, where area matters more than single-cycle throughput.

## Interface
Parameters:
- `IN_WIDTH`, 10: signed element width.
- `N`, 11: vector length, ≥1.
- `LANES`, 4: parallel add/sub units, 1 ≤ LANES ≤ N.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: global clock-enable; low freezes every register.
- `inReady`, in, 1: one-cycle pulse; A, B and `sub` are valid in that cycle.
- `sub`, in, 1: 0 computes A+B, 1 computes A−B; sampled with `inReady`.
- `A`, in, N*IN_WIDTH: flattened signed elements; element i occupies bits [i*IN_WIDTH +: IN_WIDTH].
- `B`, in, N*IN_WIDTH: same layout as `A`.
- `S`, out, N*(IN_WIDTH+1): flattened signed results; element i occupies [i*(IN_WIDTH+1) +: IN_WIDTH+1].
- `outReady`, out, 1: one-cycle pulse; `S` holds the new result.
- `earlyOutReady`, out, 1: one-cycle pulse, one cycle before `outReady`.
- `busy`, out, 1: high while a vector is being folded.
- `overrun`, out, 1: one-cycle pulse when `inReady` arrives and cannot be accepted.

## Operation
- FSM has two states:
  - IDLE → RUN on an accepted `inReady`.
  - RUN → IDLE after the last group, unless a new vector is accepted in that same cycle.
- Accept condition: `enable` and `inReady`, and either IDLE or RUN with `grp == PASSES-1`.
- On accept:
  - A, B and `sub` are captured into operand registers.
  - `grp` is cleared to 0.
  - State becomes RUN.
- In each enabled RUN cycle:
  - Lanes compute elements `grp*LANES .. grp*LANES+LANES-1` and write them into the working register.
  - `grp` increments.
- Partial last group (N not a multiple of LANES): out-of-range lanes are gated off and no write occurs.
- On the last group, the working register plus the last group's lanes are copied into `S` in the same edge. `S` therefore changes atomically and holds until the next completion.
- Arithmetic: both operands are sign-extended to IN_WIDTH+1 bits, then added or subtracted. The result is exact (no overflow) without `VECADD_SAT_EN`.
- `inReady` in any non-acceptable cycle (RUN and not the last group) → `overrun` pulse; the input is dropped and the current operation is unaffected.
- `inReady` while `enable` is low → ignored; no `overrun`.
- `reset`:
  - Clears state to IDLE and `grp` to 0.
  - Clears S, `outReady`, `earlyOutReady`, `busy` and `overrun` to 0.
  - An in-flight vector is abandoned and produces no `outReady`.

## Timing
- Reset values: S=0, outReady=0, earlyOutReady=0, busy=0, overrun=0.
- Edges are numbered from the edge that accepts `inReady` (edge 0).
  - Edges 1..PASSES: group computation.
  - `outReady`: high for the cycle after edge PASSES. Latency = PASSES cycles.
  - `earlyOutReady`: high for the cycle after edge PASSES−1. When PASSES=1 it rises at edge 0, together with acceptance.
  - `busy`: high from edge 0 through edge PASSES. It stays high on back-to-back accepts.
- Peak throughput: one vector per PASSES cycles, with `inReady` presented in the last-group cycle.
- `enable` low: all registers hold, including `outReady`/`earlyOutReady` levels. A pulse is therefore stretched while stalled.

## Configuration
- `VECADD_SAT_EN` defined:
  - Each result is clamped to [−2^(IN_WIDTH−1), 2^(IN_WIDTH−1)−1], then sign-extended into the IN_WIDTH+1-bit output field.
  - Adds output `sat`: one bit, a one-cycle pulse alongside `outReady` when any element of that vector clamped.
- Undefined: exact IN_WIDTH+1 results; no `sat` port.

## Structure
- Package `vecadd_pkg` contains:
  - the state enum (IDLE, RUN);
  - `clog2` and `passes(N,LANES)` functions;
  - the group-counter width constant.
- Sub-module `addsub_lane`: combinational sign-extend, add/sub, and optional clamp. It is instantiated LANES times inside a generate loop.
- Operand, working and output registers, plus the FSM, live in the top module.

## Test plan
- N=11, LANES=4, IN_WIDTH=10, sub=0. Stimulus: A[i]=i, B[i]=10·i. Response: `earlyOutReady` at cycle 2, `outReady` at cycle 3, S[i]=11·i; `busy` low after cycle 3.
- sub=1. Stimulus: A[0]=−512, B[0]=511. Response: S[0]=−1023, no saturation. With `VECADD_SAT_EN`: S[0]=−512 and `sat`=1.
- Back-to-back: second `inReady` in the last-group cycle. Response: second `outReady` exactly 3 cycles after the first; first S unchanged until then.
- `inReady` during group 1. Response: `overrun` pulse; original result unaffected.
- `enable` low for 2 cycles mid-run. Response: `outReady` delayed by 2 cycles; results correct.
- Reset asserted at group 1. Response: all outputs 0 next cycle; no `outReady` from the aborted vector.
- Edge configurations: LANES=N=11 (PASSES=1, earlyOutReady coincides with acceptance) and LANES=1. Response: identical S values to the default configuration.
